// File: rtl/aes_subbytes_iter.sv
// aes_subbytes_iter: iterative AES SubBytes / InvSubBytes engine.
// Each SUB cycle substitutes LANES bytes of the 16-byte state, so a block
// takes 16/LANES cycles from accept to result.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   in_valid      input block offered
//   in_ready      block can be accepted this cycle (combinational)
//   in_state      128-bit AES state, byte i = in_state[127-8i -: 8], i = 4*col+row
//   in_encrypt    1 = forward S-box, 0 = inverse S-box (sampled on accept)
//   out_valid     out_state holds a finished result
//   out_ready     consumer takes the result
//   out_state     registered result, same byte order as in_state
//   busy          high while the FSM is in SUB
//
// Optional feature: define SUBBYTES_SHIFTROWS_EN to fold ShiftRows
// (encrypt) / InvShiftRows (decrypt) into the result with no added latency.

// Combined forward/inverse S-box: shared GF(2^8) inverter (x^254) with the
// affine transform after it (forward) or its inverse before it (inverse).
module bsbox (
    input  logic [7:0] din,
    input  logic       encrypt,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] x2, x3, x6, x12, x14, x15, x240, inv;

    // x^254 = x^-1 in GF(2^8); maps 0 to 0 as AES requires
    always_comb begin
        inv_in = encrypt ? din : inv_affine(din);
        x2     = gf_mul(inv_in, inv_in);
        x3     = gf_mul(x2, inv_in);
        x6     = gf_mul(x3, x3);
        x12    = gf_mul(x6, x6);
        x14    = gf_mul(x12, x2);
        x15    = gf_mul(x12, x3);
        x240   = gf_mul(x15, x15);
        x240   = gf_mul(x240, x240);
        x240   = gf_mul(x240, x240);
        x240   = gf_mul(x240, x240);
        inv    = gf_mul(x240, x14);
        dout   = encrypt ? fwd_affine(inv) : inv;
    end

endmodule

module aes_subbytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_encrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NBYTES   = 16;
    localparam int unsigned STEPS    = NBYTES / LANES;
    localparam logic [3:0]  CTR_LAST = 4'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_iter: LANES must be 1, 2, 4 or 16");
    end

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t       state, state_next;
    logic [3:0]   ctr, ctr_next;
    logic [7:0]   work      [NBYTES];
    logic [7:0]   work_next [NBYTES];
    logic [7:0]   work_sub  [NBYTES];
    logic [127:0] sub_flat;
    logic         mode, mode_next;
    logic [127:0] out_state_next;
    logic         out_valid_next;
    logic         busy_next;
    logic         accept;
    logic [7:0]   sub_in  [LANES];
    logic [7:0]   sub_out [LANES];

    // ShiftRows: out(r,c)=in(r,c+r); InvShiftRows: out(r,c)=in(r,c-r), mod 4
    function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic enc);
        logic [127:0] y;
        int           src;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = enc ? (4 * ((c + r) & 3) + r) : (4 * ((c - r) & 3) + r);
                y[7'(127 - 8 * (4 * c + r)) -: 8] = x[7'(127 - 8 * src) -: 8];
            end
        end
        return y;
    endfunction

    assign in_ready = !RST && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // One S-box per lane, fed from the byte group selected by ctr
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign sub_in[g] = work[4'(int'(ctr) * int'(LANES) + g)];
        bsbox u_sbox (
            .din     (sub_in[g]),
            .encrypt (mode),
            .dout    (sub_out[g])
        );
    end

    // Working state with the current byte group substituted
    always_comb begin
        work_sub = work;
        for (int l = 0; l < int'(LANES); l++) begin
            work_sub[4'(int'(ctr) * int'(LANES) + l)] = sub_out[l];
        end
        sub_flat = '0;
        for (int i = 0; i < 16; i++) begin
            sub_flat[7'(127 - 8 * i) -: 8] = work_sub[i];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next     = state;
        ctr_next       = ctr;
        work_next      = work;
        mode_next      = mode;
        out_state_next = out_state;
        out_valid_next = out_valid;
        busy_next      = 1'b0;

        case (state)
            IDLE: ;
            SUB: begin
                work_next = work_sub;
                if (ctr == CTR_LAST) begin
                    ctr_next       = 4'd0;
                    state_next     = DONE;
                    out_valid_next = 1'b1;
`ifdef SUBBYTES_SHIFTROWS_EN
                    out_state_next = shift_rows(sub_flat, mode);
`else
                    out_state_next = sub_flat;
`endif
                end else begin
                    ctr_next = ctr + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Accept from IDLE, or from DONE on the same edge the result leaves
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                work_next[i] = in_state[7'(127 - 8 * i) -: 8];
            end
            mode_next  = in_encrypt;
            ctr_next   = 4'd0;
            state_next = SUB;
        end

        busy_next = (state_next == SUB);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ctr       <= 4'd0;
            mode      <= 1'b1;
            out_state <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 16; i++) work[i] <= 8'h00;
        end else begin
            state     <= state_next;
            ctr       <= ctr_next;
            mode      <= mode_next;
            out_state <= out_state_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
            work      <= work_next;
        end
    end

    // The test SUBBYTES_SHIFTROWS_EN-off build leaves shift_rows unused by design
    logic unused_sr;
    assign unused_sr = ^shift_rows(128'h0, 1'b0);

endmodule
